// File: rtl/game_pkg.sv
// Shared game constants, state encodings and the per-frame position payload.
package game_pkg;

  localparam int unsigned POS_W          = 10;
  localparam int unsigned EXT_W          = 11;
  localparam int unsigned SCORE_W        = 12;
  localparam int unsigned CNT_W          = 3;

  localparam int unsigned BIRD_X         = 100;
  localparam int unsigned BIRD_W         = 16;
  localparam int unsigned BIRD_H         = 16;
  localparam int unsigned PIPE_W         = 40;
  localparam int unsigned SCREEN_W       = 640;
  localparam int unsigned SCREEN_H       = 480;
  localparam int unsigned DEF_HIT_FRAMES = 2;

  typedef enum logic [1:0] {
    STATE_IDLE      = 2'b00,
    STATE_PLAY      = 2'b01,
    STATE_GAME_OVER = 2'b10
  } game_state_e;

  typedef enum logic [1:0] {
    DET_DISARMED = 2'b00,
    DET_ARMED    = 2'b01,
    DET_HIT      = 2'b10
  } det_state_e;

  typedef struct packed {
    logic [1:0]       game_state;
    logic [POS_W-1:0] bird_y;
    logic [POS_W-1:0] pipe_x;
    logic [POS_W-1:0] pipe_y_top;
    logic [POS_W-1:0] pipe_y_bot;
  } frame_t;

endpackage

// File: rtl/bcd_score_counter.sv
// Three-digit BCD score register; saturates at 999 and acknowledges each real increment.
module bcd_score_counter
  import game_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               inc_i,
  input  logic               clear_i,
  output logic [SCORE_W-1:0] score_o,
  output logic               inc_ack_o
);

  logic [SCORE_W-1:0] score_q, score_d;
  logic               ack_q, ack_d;

  always_comb begin
    score_d = score_q;
    ack_d   = 1'b0;
    if (clear_i) begin
      score_d = '0;
    end else if (inc_i && (score_q != 12'h999)) begin
      ack_d = 1'b1;
      if (score_q[3:0] != 4'd9) begin
        score_d[3:0] = score_q[3:0] + 4'd1;
      end else begin
        score_d[3:0] = 4'd0;
        if (score_q[7:4] != 4'd9) begin
          score_d[7:4] = score_q[7:4] + 4'd1;
        end else begin
          score_d[7:4]  = 4'd0;
          score_d[11:8] = score_q[11:8] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score_q <= '0;
      ack_q   <= 1'b0;
    end else begin
      score_q <= score_d;
      ack_q   <= ack_d;
    end
  end

  assign score_o   = score_q;
  assign inc_ack_o = ack_q;

endmodule

// File: rtl/collision_detector.sv
// Three-stage frame pipeline: sample positions, compare overlap/pass, then arm/hit FSM and scoring.
module collision_detector
  import game_pkg::*;
#(
  parameter int unsigned HIT_FRAMES = DEF_HIT_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         game_state,
  input  logic [POS_W-1:0]   bird_y,
  input  logic [POS_W-1:0]   pipe_x,
  input  logic [POS_W-1:0]   pipe_y_top,
  input  logic [POS_W-1:0]   pipe_y_bot,
  output logic               collided,
  output logic [SCORE_W-1:0] score,
  output logic               score_pulse
);

  frame_t           s1_q;
  logic             s1_valid_q;
  logic             s2_valid_q, s2_hit_q, s2_pass_q, s2_respawn_q;
  logic [1:0]       s2_state_q;
  logic [POS_W-1:0] prev_x_q;

  det_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_c;
  logic             collided_q, collided_d;
  logic             scored_q, scored_d;
  logic             active_c, inc_c, clear_c;

  logic [EXT_W-1:0] by_e, px_e, top_e, bot_e, top_c;
  logic             x_ov_c, y_ov_c, bound_c, hit_c, pass_c, respawn_c;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= enable;
      if (enable) s1_q <= {game_state, bird_y, pipe_x, pipe_y_top, pipe_y_bot};
    end
  end

  // Widened to 11 bits so bird/pipe extents never wrap past 1023.
  assign by_e      = EXT_W'(s1_q.bird_y);
  assign px_e      = EXT_W'(s1_q.pipe_x);
  assign top_e     = EXT_W'(s1_q.pipe_y_top);
  assign bot_e     = EXT_W'(s1_q.pipe_y_bot);
  assign top_c     = (top_e > bot_e) ? '0 : top_e;
  assign x_ov_c    = (px_e < EXT_W'(SCREEN_W)) && (px_e < EXT_W'(BIRD_X + BIRD_W))
                   && ((px_e + EXT_W'(PIPE_W)) > EXT_W'(BIRD_X));
  assign y_ov_c    = (by_e < top_c) || ((by_e + EXT_W'(BIRD_H)) > bot_e);
  assign bound_c   = ((by_e + EXT_W'(BIRD_H)) >= EXT_W'(SCREEN_H)) || (by_e >= EXT_W'(SCREEN_H));
  assign hit_c     = (x_ov_c && y_ov_c) || bound_c;
  assign pass_c    = (px_e + EXT_W'(PIPE_W)) < EXT_W'(BIRD_X);
  assign respawn_c = (s1_q.pipe_x > prev_x_q) || (px_e >= EXT_W'(SCREEN_W));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid_q   <= 1'b0;
      s2_hit_q     <= 1'b0;
      s2_pass_q    <= 1'b0;
      s2_respawn_q <= 1'b0;
      s2_state_q   <= STATE_IDLE;
      prev_x_q     <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_hit_q     <= hit_c;
        s2_pass_q    <= pass_c;
        s2_respawn_q <= respawn_c;
        s2_state_q   <= s1_q.game_state;
        prev_x_q     <= s1_q.pipe_x;
      end
    end
  end

  // The PLAY frame that arms the detector is already evaluated for hits and scoring.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    collided_d = collided_q;
    scored_d   = scored_q;
    inc_c      = 1'b0;
    clear_c    = 1'b0;
    cnt_inc_c  = '0;
    active_c   = (state_q == DET_ARMED) ||
                 ((state_q == DET_DISARMED) && (s2_state_q == STATE_PLAY));
    if (s2_valid_q) begin
      if (s2_respawn_q) scored_d = 1'b0;
      if ((state_q == DET_HIT) || active_c) begin
        if (s2_state_q == STATE_IDLE) begin
          state_d    = DET_DISARMED;
          cnt_d      = '0;
          collided_d = 1'b0;
          scored_d   = 1'b0;
          clear_c    = 1'b1;
        end else if (state_q != DET_HIT) begin
          if (s2_state_q == STATE_GAME_OVER) begin
            state_d    = DET_HIT;
            collided_d = 1'b1;
          end else begin
            cnt_inc_c = s2_hit_q ? (cnt_q + CNT_W'(1)) : '0;
            cnt_d     = cnt_inc_c;
            state_d   = DET_ARMED;
            if (32'(cnt_inc_c) >= HIT_FRAMES) begin
              state_d    = DET_HIT;
              collided_d = 1'b1;
            end
            if (s2_pass_q && !scored_d) begin
              inc_c    = 1'b1;
              scored_d = 1'b1;
            end
          end
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= DET_DISARMED;
      cnt_q      <= '0;
      collided_q <= 1'b0;
      scored_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      collided_q <= collided_d;
      scored_q   <= scored_d;
    end
  end

  bcd_score_counter u_score (
    .clk       (clk),
    .reset     (reset),
    .inc_i     (inc_c),
    .clear_i   (clear_c),
    .score_o   (score),
    .inc_ack_o (score_pulse)
  );

  assign collided = collided_q;

endmodule

// File: tb/tb_collision_detector.sv
// Frame-level bench for collision_detector against an integer game-rule model.
module tb_collision_detector;

  localparam int HF = 2;

  logic        clk, reset, enable;
  logic [1:0]  game_state;
  logic [9:0]  bird_y, pipe_x, pipe_y_top, pipe_y_bot;
  logic        collided, score_pulse;
  logic [11:0] score;

  int checks = 0;
  int errors = 0;

  // model state: mode 0 disarmed, 1 armed, 2 hit
  int m_mode, m_cnt, m_score, m_prev;
  bit m_scored, m_coll, m_pulse;

  logic        pre_coll, e_coll, e_pulse, o_coll, o_pulse, o_pulse_after;
  logic [11:0] pre_score, e_score, o_score;

  collision_detector dut (
    .clk(clk), .reset(reset), .enable(enable), .game_state(game_state),
    .bird_y(bird_y), .pipe_x(pipe_x), .pipe_y_top(pipe_y_top), .pipe_y_bot(pipe_y_bot),
    .collided(collided), .score(score), .score_pulse(score_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] to_bcd(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
    return {h, t, o};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_cnt = 0; m_score = 0; m_prev = 0;
    m_scored = 0; m_coll = 0; m_pulse = 0;
  endtask

  // One frame of game rules, stated directly in pixel arithmetic.
  task automatic model_frame(input int gs, input int by, input int px, input int top, input int bot);
    int topc;
    bit xov, yov, bnd, hit, pass, active;
    xov  = (px < 640) && (px < 100 + 16) && (px + 40 > 100);
    topc = (top > bot) ? 0 : top;
    yov  = (by < topc) || (by + 16 > bot);
    bnd  = (by + 16 >= 480) || (by >= 480);
    hit  = (xov && yov) || bnd;
    pass = (px + 40 < 100);
    m_pulse = 0;
    if (px > m_prev || px >= 640) m_scored = 0;
    m_prev = px;
    active = (m_mode == 1) || (m_mode == 0 && gs == 1);
    if (m_mode == 2 || active) begin
      if (gs == 0) begin
        m_mode = 0; m_cnt = 0; m_coll = 0; m_scored = 0; m_score = 0;
      end else if (m_mode != 2) begin
        if (gs == 2) begin
          m_mode = 2; m_coll = 1;
        end else begin
          m_cnt = hit ? m_cnt + 1 : 0;
          m_mode = 1;
          if (m_cnt >= HF) begin m_mode = 2; m_coll = 1; end
          if (pass && !m_scored) begin
            m_scored = 1;
            if (m_score < 999) begin m_score++; m_pulse = 1; end
          end
        end
      end
    end else begin
      m_cnt = 0;
    end
  endtask

  // Drive one strobe, update the model, and capture outputs 1, 2 and 3 clks after it.
  task automatic run_frame(input logic [1:0] gs, input logic [9:0] by, input logic [9:0] px,
                           input logic [9:0] top, input logic [9:0] bot);
    pre_coll  = m_coll;
    pre_score = to_bcd(m_score);
    model_frame(int'(gs), int'(by), int'(px), int'(top), int'(bot));
    @(negedge clk);
    game_state = gs; bird_y = by; pipe_x = px; pipe_y_top = top; pipe_y_bot = bot;
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    e_coll = collided; e_pulse = score_pulse; e_score = score;
    @(negedge clk);
    o_coll = collided; o_pulse = score_pulse; o_score = score;
    @(negedge clk);
    o_pulse_after = score_pulse;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({collided, score_pulse, score} !== 14'd0) begin
      errors++; $display("FAIL reset_values got %b/%b/%h want 0/0/000", collided, score_pulse, score);
    end
    reset = 1'b0;
    model_reset();
    run_frame(2'b01, 10'd200, 10'd640, 10'd150, 10'd350);
    run_frame(2'b01, 10'd200, 10'd0, 10'd150, 10'd350);
    checks++;
    if ({o_pulse, o_score} !== {1'b1, 12'h001}) begin
      errors++; $display("FAIL reset_prescore got %b/%h want 1/001", o_pulse, o_score);
    end
    run_frame(2'b01, 10'd470, 10'd300, 10'd150, 10'd350);
    // second floor frame is in flight when reset hits
    @(negedge clk);
    game_state = 2'b01; bird_y = 10'd470; pipe_x = 10'd300; enable = 1'b1;
    @(negedge clk);
    enable = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({collided, score_pulse, score} !== 14'd0) begin
        errors++; $display("FAIL reset_inflight cyc %0d got %b/%b/%h want 0/0/000", i, collided, score_pulse, score);
      end
    end
  endtask

  task automatic test_gap_no_hit();
    run_frame(2'b00, 10'd200, 10'd640, 10'd150, 10'd350);
    for (int i = 0; i < 4; i++) begin
      run_frame(2'b01, 10'd200, 10'd90, 10'd150, 10'd350);
      checks++;
      if (o_coll !== 1'b0) begin
        errors++; $display("FAIL gap_no_hit strobe %0d collided %b want 0", i, o_coll);
      end
    end
  endtask

  task automatic test_collision();
    run_frame(2'b00, 10'd200, 10'd640, 10'd150, 10'd350);
    run_frame(2'b01, 10'd100, 10'd90, 10'd150, 10'd350);
    checks++;
    if (o_coll !== 1'b0) begin errors++; $display("FAIL hit_first collided %b want 0", o_coll); end
    run_frame(2'b01, 10'd100, 10'd90, 10'd150, 10'd350);
    checks++;
    if ({e_coll, o_coll} !== 2'b01) begin
      errors++; $display("FAIL hit_latency early/late %b/%b want 0/1", e_coll, o_coll);
    end
    run_frame(2'b10, 10'd200, 10'd90, 10'd150, 10'd350);
    checks++;
    if (o_coll !== 1'b1) begin errors++; $display("FAIL hit_sticky collided %b want 1", o_coll); end
    run_frame(2'b00, 10'd200, 10'd640, 10'd150, 10'd350);
    checks++;
    if ({o_coll, o_score} !== 13'd0) begin
      errors++; $display("FAIL hit_idle_clear got %b/%h want 0/000", o_coll, o_score);
    end
    run_frame(2'b01, 10'd100, 10'd90, 10'd150, 10'd350);
    run_frame(2'b01, 10'd200, 10'd90, 10'd150, 10'd350);
    run_frame(2'b01, 10'd100, 10'd90, 10'd150, 10'd350);
    checks++;
    if (o_coll !== 1'b0) begin errors++; $display("FAIL hit_broken_run collided %b want 0", o_coll); end
    run_frame(2'b01, 10'd100, 10'd90, 10'd150, 10'd350);
    checks++;
    if (o_coll !== 1'b1) begin errors++; $display("FAIL hit_second_run collided %b want 1", o_coll); end
  endtask

  task automatic test_scoring();
    int pulses, pulse_px;
    pulses = 0; pulse_px = -1;
    run_frame(2'b00, 10'd200, 10'd640, 10'd150, 10'd350);
    for (int i = 0; i <= 32; i++) begin
      run_frame(2'b01, 10'd200, 10'(640 - 20 * i), 10'd150, 10'd350);
      if (o_pulse === 1'b1) begin pulses++; pulse_px = 640 - 20 * i; end
    end
    checks++;
    if (pulses !== 1 || pulse_px !== 40) begin
      errors++; $display("FAIL score_sweep pulses %0d at px %0d want 1 at 40", pulses, pulse_px);
    end
    checks++;
    if (o_score !== 12'h001) begin errors++; $display("FAIL score_sweep_value got %h want 001", o_score); end
    run_frame(2'b01, 10'd200, 10'd640, 10'd150, 10'd350);
    run_frame(2'b01, 10'd200, 10'd20, 10'd150, 10'd350);
    checks++;
    if ({o_pulse, o_score, o_pulse_after} !== {1'b1, 12'h002, 1'b0}) begin
      errors++; $display("FAIL score_respawn got %b/%h/%b want 1/002/0", o_pulse, o_score, o_pulse_after);
    end
  endtask

  task automatic test_underflow_floor();
    run_frame(2'b00, 10'd200, 10'd640, 10'd150, 10'd350);
    for (int i = 0; i < 2; i++) begin
      run_frame(2'b01, 10'd40, 10'd95, 10'd1000, 10'd80);
      checks++;
      if (o_coll !== 1'b0) begin errors++; $display("FAIL underflow strobe %0d collided %b want 0", i, o_coll); end
    end
    for (int i = 0; i < 2; i++) begin
      run_frame(2'b01, 10'd470, 10'($urandom_range(0, 1023)), 10'd150, 10'd350);
      checks++;
      if (o_coll !== (i == 1)) begin
        errors++; $display("FAIL floor strobe %0d collided %b want %0d", i, o_coll, i == 1);
      end
    end
    run_frame(2'b00, 10'd200, 10'd640, 10'd150, 10'd350);
    checks++;
    if ({o_coll, o_score} !== 13'd0) begin
      errors++; $display("FAIL floor_idle_clear got %b/%h want 0/000", o_coll, o_score);
    end
  endtask

  task automatic test_saturation();
    run_frame(2'b00, 10'd200, 10'd640, 10'd150, 10'd350);
    for (int i = 0; i < 999; i++) begin
      run_frame(2'b01, 10'd200, 10'd640, 10'd150, 10'd350);
      run_frame(2'b01, 10'd200, 10'd0, 10'd150, 10'd350);
      checks++;
      if ({o_pulse, o_score} !== {m_pulse, to_bcd(m_score)}) begin
        errors++; $display("FAIL sat_climb pipe %0d got %b/%h want %b/%h", i, o_pulse, o_score, m_pulse, to_bcd(m_score));
      end
    end
    checks++;
    if (o_score !== 12'h999) begin errors++; $display("FAIL sat_reach got %h want 999", o_score); end
    run_frame(2'b01, 10'd200, 10'd640, 10'd150, 10'd350);
    run_frame(2'b01, 10'd200, 10'd0, 10'd150, 10'd350);
    checks++;
    if ({o_pulse, o_score} !== {1'b0, 12'h999}) begin
      errors++; $display("FAIL sat_hold got %b/%h want 0/999", o_pulse, o_score);
    end
  endtask

  task automatic test_random();
    logic [1:0] gs;
    logic [9:0] by, px, top, bot;
    int r;
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 99);
      gs = (r < 75) ? 2'b01 : (r < 88) ? 2'b00 : 2'b10;
      case ($urandom_range(0, 2))
        0:       by = 10'($urandom_range(0, 1023));
        1:       by = 10'($urandom_range(140, 340));
        default: by = 10'($urandom_range(455, 490));
      endcase
      px  = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(0, 680));
      top = 10'($urandom_range(60, 250));
      bot = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(0, 1023)) : 10'(top + $urandom_range(0, 200));
      if ($urandom_range(0, 7) == 0) top = 10'($urandom_range(0, 1023));
      run_frame(gs, by, px, top, bot);
      checks++;
      if ({o_coll, o_pulse, o_score} !== {m_coll, m_pulse, to_bcd(m_score)}) begin
        errors++; $display("FAIL rand_frame %0d got %b/%b/%h want %b/%b/%h", i, o_coll, o_pulse, o_score,
                           m_coll, m_pulse, to_bcd(m_score));
      end
      checks++;
      if ({e_coll, e_pulse, e_score, o_pulse_after} !== {pre_coll, 1'b0, pre_score, 1'b0}) begin
        errors++; $display("FAIL rand_timing %0d got %b/%b/%h/%b want %b/0/%h/0", i, e_coll, e_pulse, e_score,
                           o_pulse_after, pre_coll, pre_score);
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; game_state = 2'b00;
    bird_y = '0; pipe_x = '0; pipe_y_top = '0; pipe_y_bot = '0;
    model_reset();
    test_reset();
    test_gap_no_hit();
    test_collision();
    test_scoring();
    test_underflow_floor();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
